// File: rtl/image_window_fetch_pkg.sv
// image_window_fetch_pkg: shared constants and FSM state type for the
// convolution window fetcher.
package image_window_fetch_pkg;

    localparam int DATAW         = 20;   // pixel width
    localparam int ADDRW         = 12;   // {row, col} image address width
    localparam int IMG_LOG2      = 6;    // log2 of the 64-pixel image side
    localparam int TAPS          = 9;    // taps per 3x3 window
    localparam int FRAME_WINDOWS = 4096; // one window per image pixel

    localparam logic [3:0]          LAST_TAP = 4'(TAPS - 1);
    localparam logic [IMG_LOG2-1:0] LAST_POS = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } fetchState_t;

endpackage

// File: rtl/image_window_fetch_pad_addr_gen.sv
// pad_addr_gen: maps a window centre (y, x) and tap index t to the wrapped
// image address of that tap, and flags taps that fall outside the image.
module pad_addr_gen
    import image_window_fetch_pkg::*;
(
    input  logic [IMG_LOG2-1:0] y,
    input  logic [IMG_LOG2-1:0] x,
    input  logic [3:0]          t,
    output logic [ADDRW-1:0]    iaddr,
    output logic                pad
);

    logic signed [IMG_LOG2:0] dy;
    logic signed [IMG_LOG2:0] dx;
    logic signed [IMG_LOG2:0] r;
    logic signed [IMG_LOG2:0] c;

    // Tap offsets in raster order, then source row/column with one extra
    // sign bit; the row/column is out of range exactly when that bit is set
    // (the reachable range is -1..64).
    always_comb begin
        dy = 7'sd1;
        dx = 7'sd1;
        case (t)
            4'd0, 4'd1, 4'd2: dy = -7'sd1;
            4'd3, 4'd4, 4'd5: dy = 7'sd0;
            default:          dy = 7'sd1;
        endcase
        case (t)
            4'd0, 4'd3, 4'd6: dx = -7'sd1;
            4'd1, 4'd4, 4'd7: dx = 7'sd0;
            default:          dx = 7'sd1;
        endcase
        r     = $signed({1'b0, y}) + dy;
        c     = $signed({1'b0, x}) + dx;
        iaddr = {r[IMG_LOG2-1:0], c[IMG_LOG2-1:0]};
        pad   = r[IMG_LOG2] | c[IMG_LOG2];
    end

endmodule

// File: rtl/image_window_fetch.sv
// image_window_fetch: on a ready/busy start handshake, walks all 3x3 windows
// of the 64x64 image, reads each tap through iaddr/idata and streams one tap
// per cycle to the MAC stage, zeroing padding taps.
//
// Optional build macro FETCH_STALL_CNT_EN adds the stall_cnt output, which
// counts FETCH cycles where a valid tap was held back by the consumer.
//
// Output stream handshake: a tap transfers on every posedge where
// pix_valid && pix_ready; while pix_valid is high and pix_ready is low the
// tap, its tag fields and iaddr are held unchanged, and pix_valid never
// drops before the transfer.
module image_window_fetch
    import image_window_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    input  logic [DATAW-1:0]  idata,
    input  logic              pix_ready,
    output logic              busy,
    output logic [ADDRW-1:0]  iaddr,
    output logic              pix_valid,
    output logic [DATAW-1:0]  pix_data,
    output logic [3:0]        pix_tap,
    output logic              pix_last,
    output logic [ADDRW-1:0]  win_addr,
    output logic              frame_done,
`ifdef FETCH_STALL_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    output fetchState_t       dbgState
);

    fetchState_t         state;
    fetchState_t         nextState;
    logic [IMG_LOG2-1:0] y;
    logic [IMG_LOG2-1:0] x;
    logic [3:0]          t;
    logic                issuedAll;   // final tap of the frame has been loaded
    logic                isPad;
    logic                frameStart;
    logic                adv;
    logic                finalAccept;

    pad_addr_gen u_padAddrGen (
        .y     (y),
        .x     (x),
        .t     (t),
        .iaddr (iaddr),
        .pad   (isPad)
    );

    assign frameStart  = (state == IDLE) && ready;
    assign adv         = (state == FETCH) && !issuedAll && (!pix_valid || pix_ready);
    // Once everything is issued, the slot can only hold the final tap.
    assign finalAccept = (state == FETCH) && issuedAll && pix_valid && pix_ready;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    // FSM next-state logic.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (ready) nextState = FETCH;
            FETCH:   if (finalAccept) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // FSM outputs; DONE lasts exactly one cycle, giving the frame_done pulse.
    always_comb begin
        busy       = (state != IDLE);
        frame_done = (state == DONE);
        dbgState   = state;
    end

    // Window/tap counters: tap fastest, then column, then row.
    always_ff @(posedge clk) begin
        if (!reset || frameStart) begin
            y         <= '0;
            x         <= '0;
            t         <= '0;
            issuedAll <= 1'b0;
        end else if (adv) begin
            if (t == LAST_TAP) begin
                t <= 4'd0;
                x <= x + 6'd1;
                if (x == LAST_POS) y <= y + 6'd1;
            end else begin
                t <= t + 4'd1;
            end
            if (y == LAST_POS && x == LAST_POS && t == LAST_TAP) issuedAll <= 1'b1;
        end
    end

    // Output slot: load the fetched tap on advance, empty it when consumed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_tap   <= '0;
            pix_last  <= 1'b0;
            win_addr  <= '0;
        end else if (adv) begin
            pix_valid <= 1'b1;
            pix_data  <= isPad ? '0 : idata;
            pix_tap   <= t;
            pix_last  <= (t == LAST_TAP);
            win_addr  <= {y, x};
        end else if (pix_valid && pix_ready) begin
            pix_valid <= 1'b0;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    // Saturating count of consumer-stalled FETCH cycles, restarted per frame.
    always_ff @(posedge clk) begin
        if (!reset || frameStart) begin
            stall_cnt <= '0;
        end else if (state == FETCH && pix_valid && !pix_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_image_window_fetch.sv
// tb_image_window_fetch: directed bench for image_window_fetch with an
// expected-tap queue built from an independent geometry model.
module tb_image_window_fetch;
  import image_window_fetch_pkg::*;

`ifdef FETCH_STALL_CNT_EN
  localparam int N_STALL = 7;
`else
  localparam int N_STALL = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              ready;
  logic [DATAW-1:0]  idata;
  logic              pix_ready;
  logic              busy;
  logic [ADDRW-1:0]  iaddr;
  logic              pix_valid;
  logic [DATAW-1:0]  pix_data;
  logic [3:0]        pix_tap;
  logic              pix_last;
  logic [ADDRW-1:0]  win_addr;
  logic              frame_done;
  fetchState_t       dbg_state;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  // image memory model: mem[a] = a + 1
  always_comb idata = DATAW'(iaddr) + DATAW'(1);

  image_window_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .ready      (ready),
    .idata      (idata),
    .pix_ready  (pix_ready),
    .busy       (busy),
    .iaddr      (iaddr),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_tap    (pix_tap),
    .pix_last   (pix_last),
    .win_addr   (win_addr),
    .frame_done (frame_done),
`ifdef FETCH_STALL_CNT_EN
    .stall_cnt  (stall_cnt),
`endif
    .dbgState   (dbg_state)
  );

  // expected record: {win_addr, tap, last, data}
  logic [36:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;
  int tap_cnt = 0;
  int last_cnt = 0;
  int done_cnt = 0;
  int busy_cyc = 0;
  bit mon_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [36:0] tap_model(input int wy, input int wx, input int tp);
    int r;
    int c;
    logic [19:0] d;
    r = wy + tp / 3 - 1;
    c = wx + tp % 3 - 1;
    if (r < 0 || r > 63 || c < 0 || c > 63) d = 20'd0;
    else d = 20'(r * 64 + c + 1);
    return {12'(wy * 64 + wx), 4'(tp), (tp == 8), d};
  endfunction

  task automatic push_frame();
    for (int wy = 0; wy < 64; wy++)
      for (int wx = 0; wx < 64; wx++)
        for (int tp = 0; tp < 9; tp++)
          exp_q.push_back(tap_model(wy, wx, tp));
  endtask

  // monitor the current cycle at the negedge, then step to 1ns after the next posedge
  task automatic cycle();
    logic [36:0] e;
    bit avail;
    @(negedge clk);
    if (busy) busy_cyc++;
    if (mon_en && frame_done) begin
      done_cnt++;
      check("done_state", 64'(dbg_state), 64'(DONE));
    end
    if (mon_en && pix_valid && pix_ready) begin
      tap_cnt++;
      if (pix_last) last_cnt++;
      avail = (exp_q.size() != 0);
      check("stream_avail", 64'(avail), 64'd1);
      if (avail) begin
        e = exp_q.pop_front();
        check("stream_tap", 64'({win_addr, pix_tap, pix_last, pix_data}), 64'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"},       64'(busy),       64'd0);
    check({tag, "_valid"},      64'(pix_valid),  64'd0);
    check({tag, "_data"},       64'(pix_data),   64'd0);
    check({tag, "_tap"},        64'(pix_tap),    64'd0);
    check({tag, "_last"},       64'(pix_last),   64'd0);
    check({tag, "_win"},        64'(win_addr),   64'd0);
    check({tag, "_done"},       64'(frame_done), 64'd0);
    check({tag, "_iaddr"},      64'(iaddr),      64'hFFF);
    check({tag, "_state"},      64'(dbg_state),  64'(IDLE));
  endtask

  initial begin
    int t0;
    int l0;
    int d0;
    int b0;
    logic [DATAW-1:0] h_data;
    logic [3:0]       h_tap;
    logic [ADDRW-1:0] h_win;
    logic [ADDRW-1:0] h_iaddr;

    // clock/reset
    reset = 1'b0;
    ready = 1'b0;
    pix_ready = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) cycle();
    check_reset("por");
    reset = 1'b1;
    cycle();

    // frame 1: full frame, consumer always ready except optional stall burst
    push_frame();
    mon_en = 1'b1;
    t0 = tap_cnt; l0 = last_cnt; d0 = done_cnt; b0 = busy_cyc;
    ready = 1'b1;
    cycle();
    ready = 1'b0;
    check("start_busy",     64'(busy),      64'd1);
    check("start_iaddr",    64'(iaddr),     64'hFFF);
    check("start_no_valid", 64'(pix_valid), 64'd0);
    cycle();
    check("first_valid", 64'(pix_valid), 64'd1);
    check("first_tap",   64'(pix_tap),   64'd0);
    check("first_data",  64'(pix_data),  64'd0);
    check("first_win",   64'(win_addr),  64'd0);
    for (int i = 0; i < 40000 && busy; i++) begin
      pix_ready = !(i >= 100 && i < 100 + N_STALL);
      cycle();
    end
    pix_ready = 1'b1;
    check("f1_timeout",     64'(busy),              64'd0);
    check("f1_taps",        64'(tap_cnt - t0),      64'd36864);
    check("f1_lasts",       64'(last_cnt - l0),     64'(FRAME_WINDOWS));
    check("f1_done_pulses", 64'(done_cnt - d0),     64'd1);
    check("f1_busy_cycles", 64'(busy_cyc - b0),     64'(36866 + N_STALL));
    check("f1_queue_empty", 64'(exp_q.size()),      64'd0);
`ifdef FETCH_STALL_CNT_EN
    check("f1_stall_cnt",   64'(stall_cnt),         64'd7);
`endif

    // frame 2: backpressure burst, then reset mid-frame
    push_frame();
    t0 = tap_cnt;
    ready = 1'b1;
    cycle();
    ready = 1'b0;
    check("f2_start_busy", 64'(busy), 64'd1);
`ifdef FETCH_STALL_CNT_EN
    check("f2_stall_clear", 64'(stall_cnt), 64'd0);
`endif
    for (int i = 0; i < 100 && (tap_cnt - t0) < 20; i++) cycle();
    pix_ready = 1'b0;
    h_data = pix_data; h_tap = pix_tap; h_win = win_addr; h_iaddr = iaddr;
    check("bp_valid", 64'(pix_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (i < 4) begin
        check("bp_data",  64'(pix_data), 64'(h_data));
        check("bp_tap",   64'(pix_tap),  64'(h_tap));
        check("bp_win",   64'(win_addr), 64'(h_win));
        check("bp_iaddr", 64'(iaddr),    64'(h_iaddr));
      end
    end
    pix_ready = 1'b1;
    for (int i = 0; i < 2000 && (tap_cnt - t0) < 1000; i++) cycle();
    check("f2_reach_1000", 64'((tap_cnt - t0) >= 1000), 64'd1);
    reset = 1'b0;
    mon_en = 1'b0;
    cycle();
    check_reset("midrst");
    reset = 1'b1;
    exp_q.delete();
    cycle();
    check("post_rst_done", 64'(frame_done), 64'd0);
    check("post_rst_busy", 64'(busy),       64'd0);

    // frame 3: restart must begin at window (0,0)
    push_frame();
    mon_en = 1'b1;
    t0 = tap_cnt;
    ready = 1'b1;
    cycle();
    ready = 1'b0;
    check("f3_start_busy",  64'(busy),  64'd1);
    check("f3_start_iaddr", 64'(iaddr), 64'hFFF);
    repeat (40) cycle();
    check("f3_taps", 64'(tap_cnt - t0), 64'd39);
    mon_en = 1'b0;
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    exp_q.delete();
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
